// File: rtl/quick_uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte channel between NUM_REQ
// requesters; a grant is held for a whole message or until the owner idles out.
module quick_uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_BITS    = 8,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]             req_last_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic                           tx_valid_o,
  output logic [DATA_BITS-1:0]           tx_data_o,
  input  logic                           tx_ready_i,
  output logic [NUM_REQ-1:0]             grant_o,
  output logic                           timeout_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  localparam logic [CW-1:0] CNT_LAST = CW'(IDLE_TIMEOUT - 1);
  localparam logic [PW-1:0] PTR_RST  = PW'(NUM_REQ - 1);

  logic [0:0]    state_q, state_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;

  logic [PW-1:0]        pick;
  logic                 gnt;
  logic                 own_v;
  logic                 own_l;
  logic [DATA_BITS-1:0] own_d;
  logic                 hs;
  int                   j;

  // Search downward so the closest index after the pointer wins last.
  always_comb begin
    pick = '0;
    j    = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      j = (int'(ptr_q) + i) % NUM_REQ;
      if (req_valid_i[j]) begin
        pick = PW'(j);
      end
    end
  end

  assign gnt   = (state_q == S_GRANT);
  assign own_v = req_valid_i[owner_q];
  assign own_l = req_last_i[owner_q];
  assign own_d = req_data_i[int'(owner_q)*DATA_BITS +: DATA_BITS];

  assign tx_valid_o  = gnt & own_v;
  assign tx_data_o   = gnt ? own_d : '0;
  assign req_ready_o = gnt ? (NUM_REQ'(tx_ready_i) << owner_q) : '0;
  assign grant_o     = gnt ? (NUM_REQ'(1'b1) << owner_q) : '0;
  assign timeout_o   = to_q;
  assign hs          = tx_valid_o & tx_ready_i;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req_valid_i) begin
          state_d = S_GRANT;
          owner_d = pick;
          cnt_d   = '0;
        end
      end
      S_GRANT: begin
        if (hs && own_l) begin
          state_d = S_IDLE;
          ptr_d   = owner_q;
        end else if (own_v) begin
          cnt_d = '0;
        end else if (IDLE_TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          ptr_d   = owner_q;
          to_d    = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      ptr_q   <= PTR_RST;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

endmodule

// File: tb/tb_quick_uart_tx_arbiter.sv
// Randomized scoreboard bench for quick_uart_tx_arbiter against a
// transaction-level model of message-locked round-robin arbitration.
module tb_quick_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DB = 8;
  localparam int TO = 8;

  logic          clk;
  logic          rst;
  logic [N-1:0]  rv;
  logic [N*DB-1:0] rd;
  logic [N-1:0]  rl;
  logic [N-1:0]  rr;
  logic          txv;
  logic [DB-1:0] txd;
  logic          rdy;
  logic [N-1:0]  gnt;
  logic          tmo;

  quick_uart_tx_arbiter #(
    .NUM_REQ(N), .DATA_BITS(DB), .IDLE_TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(rv), .req_data_i(rd), .req_last_i(rl),
    .req_ready_o(rr), .tx_valid_o(txv), .tx_data_o(txd),
    .tx_ready_i(rdy), .grant_o(gnt), .timeout_o(tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  g;
    logic [N-1:0]  r;
    logic          v;
    logic [DB-1:0] d;
    logic          dchk;
    logic          t;
  } cyc_t;

  typedef struct packed {
    logic [N-1:0]  g;
    logic [DB-1:0] d;
  } byte_t;

  cyc_t  cq[$];
  byte_t bq[$];

  int checks = 0;
  int failures = 0;

  int m_own, m_ptr, m_low;
  bit m_to;
  int m_hs_n = 0, m_to_n = 0;
  int d_hs_n = 0, d_to_n = 0;

  bit         hold[N];
  logic [7:0] hd[N];
  bit         hl[N];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs, push expectations, advance model, clock.
  task automatic cyc(input int pv, input int plast, input int prdy,
                     input bit rst_now);
    cyc_t  e;
    byte_t b;
    bit    v;
    bit    found;
    int    idx;
    for (int k = 0; k < N; k++) begin
      if (!hold[k] && $urandom_range(99) < pv) begin
        hold[k] = 1'b1;
        hd[k]   = 8'($urandom);
        hl[k]   = ($urandom_range(99) < plast);
      end
      rv[k] = hold[k];
      rd[k*DB +: DB] = hold[k] ? hd[k] : 8'($urandom);
      rl[k] = hold[k] ? hl[k] : 1'($urandom);
    end
    rdy = ($urandom_range(99) < prdy);
    rst = rst_now;

    v      = (m_own >= 0) && hold[m_own];
    e.g    = (m_own >= 0) ? N'(1) << m_own : '0;
    e.r    = (m_own >= 0 && rdy) ? N'(1) << m_own : '0;
    e.v    = v;
    e.d    = v ? hd[m_own] : 8'h00;
    e.dchk = v || (m_own < 0);
    e.t    = m_to;
    cq.push_back(e);

    if (rst_now) begin
      m_own = -1; m_ptr = N - 1; m_low = 0; m_to = 0;
    end else if (m_own < 0) begin
      m_to  = 0;
      found = 0;
      for (int i = 1; i <= N; i++) begin
        idx = (m_ptr + i) % N;
        if (!found && hold[idx]) begin
          found = 1; m_own = idx; m_low = 0;
        end
      end
    end else begin
      m_to = 0;
      if (v && rdy) begin
        b.g = e.g; b.d = hd[m_own];
        bq.push_back(b);
        m_hs_n++;
        hold[m_own] = 1'b0;
        if (hl[m_own]) begin
          m_ptr = m_own; m_own = -1;
        end
      end else if (v) begin
        m_low = 0;
      end else begin
        m_low++;
        if (m_low == TO) begin
          m_ptr = m_own; m_own = -1; m_to = 1; m_to_n++;
        end
      end
      if (v) m_low = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc_t  e;
    byte_t b;
    forever begin
      @(negedge clk);
      if (cq.size() > 0) begin
        e = cq.pop_front();
        chk("grant", 32'(gnt), 32'(e.g));
        chk("ready", 32'(rr), 32'(e.r));
        chk("tx_valid", 32'(txv), 32'(e.v));
        chk("timeout", 32'(tmo), 32'(e.t));
        if (e.dchk) chk("tx_data", 32'(txd), 32'(e.d));
        if (tmo) d_to_n++;
        if (!rst && txv && rdy) begin
          d_hs_n++;
          if (bq.size() == 0) begin
            chk("unexpected_byte", 32'(txd), 32'hFFFF_FFFF);
          end else begin
            b = bq.pop_front();
            chk("byte_owner", 32'(gnt), 32'(b.g));
            chk("byte_data", 32'(txd), 32'(b.d));
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; rv = '0; rd = '0; rl = '0; rdy = 1'b0;
    for (int k = 0; k < N; k++) begin
      hold[k] = 0; hd[k] = 8'h00; hl[k] = 0;
    end
    m_own = -1; m_ptr = N - 1; m_low = 0; m_to = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < 400; c++) cyc(100, 100, 100, 1'b0);
    for (int c = 0; c < 500; c++) cyc(100, 25, 70, 1'b0);
    for (int c = 0; c < 800; c++) cyc(8, 40, 80, 1'b0);
    for (int c = 0; c < 500; c++) cyc(60, 50, 5, 1'b0);
    for (int c = 0; c < 800; c++)
      cyc(50, 50, 60, ($urandom_range(99) < 2));
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bytes_left", 32'(bq.size()), 32'd0);
    chk("handshake_count", 32'(d_hs_n), 32'(m_hs_n));
    chk("timeout_count", 32'(d_to_n), 32'(m_to_n));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/quick_uart_tx_arbiter.md
Name: quick_uart_tx_arbiter

Overview:
Shares one quick_uart_tx byte channel between NUM_REQ independent byte-stream requesters (e.g. debug console, telemetry, command responses). Uses round-robin arbitration with message lock: once granted, a requester keeps the transmitter until it sends a byte flagged last, or until it stalls past an idle timeout. It sits between the requesters and the UART TX valid/ready/data port and is a pure pass-through while granted.

Parameters:
NUM_REQ, 4, number of requesters (2..16).
DATA_BITS, 8, byte width; must match the downstream UART DATA_BITS.
IDLE_TIMEOUT, 1024, cycles a granted requester may hold valid low before its grant is revoked; 0 disables the timeout.

Ports:
clk_i  input  1  clock.
rst_i  input  1  reset; synchronous, active-high.
req_valid_i  input  NUM_REQ  per-requester byte valid.
req_data_i  input  NUM_REQ*DATA_BITS  per-requester byte; requester k occupies bits [k*DATA_BITS +: DATA_BITS].
req_last_i  input  NUM_REQ  byte is last of message; releases grant on handshake.
req_ready_o  output  NUM_REQ  per-requester ready.
tx_valid_o  output  1  to UART valid_i.
tx_data_o  output  DATA_BITS  to UART data_i.
tx_ready_i  input  1  from UART ready_o.
grant_o  output  NUM_REQ  one-hot current owner; all zero when idle.
timeout_o  output  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (clk_i edge with rst_i=1): state IDLE; grant_o=0; req_ready_o=0; tx_valid_o=0; timeout_o=0; idle counter=0; round-robin pointer = NUM_REQ-1, so requester 0 has top priority first. Reset mid-message aborts the grant without completing the message; a handshake in the same cycle is ignored.
- States: IDLE, GRANTED.
- IDLE: all req_ready_o=0, tx_valid_o=0. If any req_valid_i=1, select the first asserted index searching from pointer+1 upward with wrap modulo NUM_REQ. Register it into grant_o; go to GRANTED. Latency: request to tx_valid_o is 1 cycle.
- GRANTED, owner g (combinational pass-through):
  - tx_valid_o = req_valid_i[g]; tx_data_o = req_data_i[g].
  - req_ready_o[g] = tx_ready_i; all other ready bits are 0.
  - Handshake = req_valid_i[g] & tx_ready_i.
- Leaving GRANTED via handshake with req_last_i[g]=1: next cycle goes to IDLE, pointer <= g, grant_o <= 0. New arbitration occurs in IDLE, so there is one dead cycle between messages.
- Idle counter, in GRANTED only:
  - Clears on req_valid_i[g]=1.
  - Otherwise increments, saturating.
  - When IDLE_TIMEOUT != 0 and the counter reaches IDLE_TIMEOUT-1 with valid still low: next cycle go to IDLE, pointer <= g, timeout_o=1 for exactly one cycle.
  - The counter clears on entry to GRANTED.
- Same cycle as last-handshake: the timeout cannot fire, because valid is high.
- tx_data_o when tx_valid_o=0 is don't-care; drive 0 in IDLE.
- Requester protocol: once valid is asserted it holds data/last stable until handshake. The arbiter does not check this.
- The UART's ready_o stays low while transmitting; the arbiter only forwards ready and never buffers bytes.
- Pointer width $clog2(NUM_REQ); wrap from NUM_REQ-1 to 0.

Test Plan:
- Single requester: reset, req 2 sends 3 bytes 0x41,0x42,0x43 with last on 0x43 → grant_o=4'b0100 one cycle after valid; tx_data_o sequence 0x41,0x42,0x43; IDLE afterward; grant_o=0.
- Fairness: all 4 requesters hold valid with 1-byte messages (last=1) continuously → grant order 0,1,2,3,0,1; each grant separated by one IDLE cycle.
- Message lock: req 0 sends 4-byte message while req 1 valid throughout → req_ready_o[1]=0 until req 0's last handshake; req 1 granted on the following arbitration.
- Timeout: IDLE_TIMEOUT=8; req 3 granted, sends 1 non-last byte, then drops valid → timeout_o pulses once 8 cycles after valid drops; grant released; pointer=3, so a pending req 0 wins next.
- Backpressure: tx_ready_i held low 20 cycles with req 1 granted and valid → tx_valid_o=1, data stable, no handshake, no timeout.
- Reset mid-message: rst_i asserted during req 2's second byte → next cycle grant_o=0, tx_valid_o=0, pointer=NUM_REQ-1; req 0 wins if requesting.
